icache_fill_ctrl: RTL and testbench

Direct-mapped, read-only instruction cache and controller that generates `instr_mem_resp` for the pipeline's stall control unit. It is the responder side of the IF-stage fetch handshake: it returns hits in the request cycle, runs a 4-beat line fill from the cacheline adaptor on a miss, and honors the stall unit's `continue_i_cache` hold. It sits between the IF stage and the memory arbiter's instruction port.

---
 rtl/icache_fill_ctrl.sv | 138 +++++++++++++
 tb/tb_icache_fill_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_ctrl.sv
// ============================================================================
// icache_fill_ctrl : direct-mapped read-only I-cache with a 4-beat line filler
// Revision 1.0
// ============================================================================
`default_nettype none

module icache_fill_ctrl #(
  parameter int S_INDEX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_mem_read,
  input  logic [31:0] instr_mem_address,
  output logic [31:0] instr_mem_rdata,
  output logic        instr_mem_resp,
  input  logic        continue_i_cache,
  input  logic        inval_req,
  output logic        pmem_read,
  output logic [31:0] pmem_address,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 32 - 5 - S_INDEX;

  typedef enum logic [1:0] {
    CHECK = 2'd0,
    FILL  = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [255:0]      data_q [SETS];
  logic [191:0]      buf_q, buf_d;
  logic [1:0]        beat_q, beat_d;
  logic [31:0]       line_q, line_d;
  logic              pend_q, pend_d;

  logic [S_INDEX-1:0] req_idx_w, fill_idx_w;
  logic [TAG_W-1:0]   req_tag_w, fill_tag_w;
  logic               hit_w, fill_done_w;
  logic               unused_addr_bits;

  assign req_idx_w   = instr_mem_address[5+S_INDEX-1:5];
  assign req_tag_w   = instr_mem_address[31:5+S_INDEX];
  assign fill_idx_w  = line_q[5+S_INDEX-1:5];
  assign fill_tag_w  = line_q[31:5+S_INDEX];
  assign unused_addr_bits = ^instr_mem_address[1:0];

  // A pending invalidate forces every lookup in the first CHECK cycle to miss.
  assign hit_w       = instr_mem_read && valid_q[req_idx_w] &&
                       (tag_q[req_idx_w] == req_tag_w) && !pend_q;
  assign fill_done_w = (state_q == FILL) && pmem_resp && (beat_q == 2'd3);
  assign pmem_address = line_q;

  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    buf_d           = buf_q;
    beat_d          = beat_q;
    line_d          = line_q;
    pend_d          = pend_q;
    instr_mem_resp  = 1'b0;
    instr_mem_rdata = 32'd0;
    pmem_read       = 1'b0;
    case (state_q)
      CHECK: begin
        if (!instr_mem_read) begin
          instr_mem_resp = 1'b1;
        end else if (hit_w) begin
          instr_mem_resp  = 1'b1;
          instr_mem_rdata = data_q[req_idx_w][{instr_mem_address[4:2], 5'b0} +: 32];
        end else if (continue_i_cache) begin
          line_d  = {instr_mem_address[31:5], 5'b0};
          beat_d  = 2'd0;
          state_d = FILL;
        end
        if (inval_req || pend_q) begin
          valid_d = '0;
          pend_d  = 1'b0;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (inval_req) pend_d = 1'b1;
        if (pmem_resp) begin
          beat_d = beat_q + 2'd1;
          case (beat_q)
            2'd0:    buf_d[63:0]    = pmem_rdata;
            2'd1:    buf_d[127:64]  = pmem_rdata;
            2'd2:    buf_d[191:128] = pmem_rdata;
            default: begin
              valid_d[fill_idx_w] = 1'b1;
              state_d             = DONE;
            end
          endcase
        end
      end
      DONE: begin
        if (inval_req) pend_d = 1'b1;
        state_d = CHECK;
      end
      default: state_d = CHECK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CHECK;
      valid_q <= '0;
      buf_q   <= '0;
      beat_q  <= 2'd0;
      line_q  <= 32'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      buf_q   <= buf_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      pend_q  <= pend_d;
    end
  end

  // Line storage carries no reset; the valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (fill_done_w) begin
      data_q[fill_idx_w] <= {pmem_rdata, buf_q};
      tag_q[fill_idx_w]  <= fill_tag_w;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_fill_ctrl.sv
// ============================================================================
// tb_icache_fill_ctrl : randomized self-checking bench with a cache-level model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_icache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_mem_read;
  logic [31:0] instr_mem_address;
  logic [31:0] instr_mem_rdata;
  logic        instr_mem_resp;
  logic        continue_i_cache;
  logic        inval_req;
  logic        pmem_read;
  logic [31:0] pmem_address;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  int checks   = 0;
  int failures = 0;
  int beats_total = 0;
  int adp_beat    = 0;
  bit fast        = 1'b1;

  // Reference model: which line each set holds
  bit          mv [16];
  logic [22:0] mt [16];

  icache_fill_ctrl #(.S_INDEX(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .instr_mem_read    (instr_mem_read),
    .instr_mem_address (instr_mem_address),
    .instr_mem_rdata   (instr_mem_rdata),
    .instr_mem_resp    (instr_mem_resp),
    .continue_i_cache  (continue_i_cache),
    .inval_req         (inval_req),
    .pmem_read         (pmem_read),
    .pmem_address      (pmem_address),
    .pmem_rdata        (pmem_rdata),
    .pmem_resp         (pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Adaptor: counts accepted beats, supplies up to four beats per request
  always @(posedge clk) begin
    if (pmem_read && pmem_resp) begin
      beats_total <= beats_total + 1;
      adp_beat    <= adp_beat + 1;
    end else if (!pmem_read) begin
      adp_beat <= 0;
    end
  end

  always @(negedge clk) begin
    if (pmem_read && adp_beat < 4 && (fast || $urandom_range(0, 1) == 1)) begin
      pmem_resp  = 1'b1;
      pmem_rdata = {memword(pmem_address + 32'(adp_beat * 8 + 4)),
                    memword(pmem_address + 32'(adp_beat * 8))};
    end else begin
      pmem_resp  = 1'b0;
      pmem_rdata = {$urandom, $urandom};
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  // Present a read with continue=1 and follow it to completion.
  task automatic do_read(input logic [31:0] a, input int exp_lat);
    int          idx;
    logic [22:0] tg;
    bit          exp_hit;
    bit          addr_bad;
    int          b0;
    int          n;
    int          rd_cycles;
    idx     = int'(a[8:5]);
    tg      = a[31:9];
    exp_hit = mv[idx] && (mt[idx] == tg);
    @(posedge clk); #1;
    instr_mem_read    = 1'b1;
    instr_mem_address = a;
    continue_i_cache  = 1'b1;
    b0 = beats_total;
    @(negedge clk);
    checks++;
    if (exp_hit) begin
      if (instr_mem_resp !== 1'b1 || instr_mem_rdata !== memword(a)) begin
        failures++;
        $display("FAIL hit @%h: resp=%b rdata=%h, want resp=1 rdata=%h",
                 a, instr_mem_resp, instr_mem_rdata, memword(a));
      end
    end else begin
      if (instr_mem_resp !== 1'b0) begin
        failures++;
        $display("FAIL miss_first_cycle @%h: resp=%b, want 0", a, instr_mem_resp);
      end
      n = 1; rd_cycles = 0; addr_bad = 1'b0;
      while (instr_mem_resp !== 1'b1 && n < 60) begin
        if (pmem_read === 1'b1) begin
          rd_cycles++;
          if (pmem_address !== {a[31:5], 5'b0}) addr_bad = 1'b1;
        end
        @(negedge clk);
        n++;
      end
      checks++;
      if (instr_mem_resp !== 1'b1 || instr_mem_rdata !== memword(a)) begin
        failures++;
        $display("FAIL miss_data @%h: resp=%b rdata=%h, want resp=1 rdata=%h",
                 a, instr_mem_resp, instr_mem_rdata, memword(a));
      end
      checks++;
      if (beats_total - b0 != 4 || addr_bad) begin
        failures++;
        $display("FAIL fill_beats @%h: beats=%0d addr_bad=%0b, want 4 beats at %h",
                 a, beats_total - b0, addr_bad, {a[31:5], 5'b0});
      end
      if (exp_lat != 0) begin
        checks++;
        if (n != exp_lat || rd_cycles != 4) begin
          failures++;
          $display("FAIL miss_latency @%h: cycles=%0d pmem_read_cycles=%0d, want %0d and 4",
                   a, n, rd_cycles, exp_lat);
        end
      end
      mv[idx] = 1'b1;
      mt[idx] = tg;
    end
  endtask

  task automatic check_idle();
    @(posedge clk); #1;
    instr_mem_read    = 1'b0;
    instr_mem_address = $urandom;
    @(negedge clk);
    checks++;
    if (instr_mem_resp !== 1'b1 || instr_mem_rdata !== 32'd0) begin
      failures++;
      $display("FAIL idle: resp=%b rdata=%h, want resp=1 rdata=0",
               instr_mem_resp, instr_mem_rdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    instr_mem_read = 1'b0; instr_mem_address = 32'h0;
    continue_i_cache = 1'b1; inval_req = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pmem_read !== 1'b0 || pmem_address !== 32'd0 ||
        instr_mem_resp !== 1'b1 || instr_mem_rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_idle: pmem_read=%b pmem_address=%h resp=%b rdata=%h, want 0 0 1 0",
               pmem_read, pmem_address, instr_mem_resp, instr_mem_rdata);
    end
    instr_mem_read = 1'b1; instr_mem_address = 32'h40;
    #1;
    checks++;
    if (instr_mem_resp !== 1'b0) begin
      failures++;
      $display("FAIL reset_read: resp=%b, want 0", instr_mem_resp);
    end
    instr_mem_read = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_cold_miss();
    fast = 1'b1;
    do_read(32'h0000_0040, 7);
    do_read(32'h0000_005C, 0);
    do_read(32'h0000_0048, 0);
  endtask

  task automatic test_conflict();
    fast = 1'b1;
    do_read(32'h0000_0000, 0);
    do_read(32'h0000_0200, 0);
    do_read(32'h0000_0004, 0);
  endtask

  task automatic test_hold();
    int n;
    int b0;
    @(posedge clk); #1;
    instr_mem_read = 1'b1; instr_mem_address = 32'h0000_01A0; continue_i_cache = 1'b0;
    b0 = beats_total;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (instr_mem_resp !== 1'b0 || pmem_read !== 1'b0) begin
        failures++;
        $display("FAIL hold cycle %0d: resp=%b pmem_read=%b, want 0 0",
                 i, instr_mem_resp, pmem_read);
      end
    end
    @(posedge clk); #1 continue_i_cache = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_01A0) begin
      failures++;
      $display("FAIL hold_release: pmem_read=%b pmem_address=%h, want 1 000001a0",
               pmem_read, pmem_address);
    end
    n = 0;
    while (instr_mem_resp !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (instr_mem_resp !== 1'b1 || instr_mem_rdata !== memword(32'h1A0) ||
        beats_total - b0 != 4) begin
      failures++;
      $display("FAIL hold_fill: resp=%b rdata=%h beats=%0d, want 1 %h 4",
               instr_mem_resp, instr_mem_rdata, beats_total - b0, memword(32'h1A0));
    end
    mv[13] = 1'b1; mt[13] = 23'd0;
  endtask

  task automatic test_inval_fill();
    int n;
    int b0;
    fast = 1'b1;
    @(posedge clk); #1;
    instr_mem_read = 1'b1; instr_mem_address = 32'h0000_03E4; continue_i_cache = 1'b1;
    b0 = beats_total;
    n = 0;
    while (beats_total < b0 + 2 && n < 60) begin @(negedge clk); n++; end
    inval_req = 1'b1;
    @(posedge clk); #1 inval_req = 1'b0;
    n = 0;
    while (instr_mem_resp !== 1'b1 && n < 80) begin @(negedge clk); n++; end
    checks++;
    if (instr_mem_resp !== 1'b1 || instr_mem_rdata !== memword(32'h3E4) ||
        beats_total - b0 != 8) begin
      failures++;
      $display("FAIL inval_during_fill: resp=%b rdata=%h beats=%0d, want 1 %h 8",
               instr_mem_resp, instr_mem_rdata, beats_total - b0, memword(32'h3E4));
    end
    model_clear();
    mv[15] = 1'b1; mt[15] = 23'd1;
  endtask

  task automatic test_inval_check();
    @(posedge clk); #1;
    instr_mem_read = 1'b1; instr_mem_address = 32'h0000_03E8;
    continue_i_cache = 1'b1; inval_req = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_mem_resp !== 1'b1 || instr_mem_rdata !== memword(32'h3E8)) begin
      failures++;
      $display("FAIL inval_same_cycle_hit: resp=%b rdata=%h, want 1 %h",
               instr_mem_resp, instr_mem_rdata, memword(32'h3E8));
    end
    @(posedge clk); #1 inval_req = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_mem_resp !== 1'b0) begin
      failures++;
      $display("FAIL inval_next_cycle: resp=%b, want 0", instr_mem_resp);
    end
    model_clear();
    do_read(32'h0000_03E8, 0);
  endtask

  task automatic test_reset_mid_fill();
    int n;
    int b0;
    fast = 1'b1;
    @(posedge clk); #1;
    instr_mem_read = 1'b1; instr_mem_address = 32'h0000_0124; continue_i_cache = 1'b1;
    b0 = beats_total;
    n = 0;
    while (beats_total < b0 + 2 && n < 60) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    instr_mem_read = 1'b0;
    #1;
    checks++;
    if (pmem_read !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_fill: pmem_read=%b, want 0", pmem_read);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_clear();
    do_read(32'h0000_0124, 7);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [22:0] tg;
    for (int i = 0; i < 80; i++) begin
      fast = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) begin
        check_idle();
      end else begin
        tg = ($urandom_range(0, 4) == 4) ? 23'h7F_FFFF : 23'($urandom_range(0, 2));
        a  = {tg, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31))};
        do_read(a, 0);
      end
    end
  endtask

  initial begin
    pmem_resp = 1'b0;
    pmem_rdata = 64'd0;
    test_reset();
    test_cold_miss();
    test_conflict();
    check_idle();
    test_hold();
    test_inval_fill();
    test_inval_check();
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
